// File: rtl/deser_1_to_8_pkg.sv
`default_nettype none
// ============================================================================
// Module  : deser_1_to_8_pkg
// Brief   : Shared widths, default bit rate and run-state encoding.
// Revision: 1.0
// ============================================================================
package deser_1_to_8_pkg;

    localparam int RATE_DEFAULT = 50000000;
    localparam int IDX_W        = 3;
    localparam int BYTE_W       = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/deser_1_to_8_tick_div.sv
`default_nettype none
// ============================================================================
// Module  : tick_div
// Brief   : Bit-period divider; one-cycle tick at the last count while enabled.
// Revision: 1.0
// ============================================================================
import deser_1_to_8_pkg::*;

module tick_div #(
    parameter int RATE = RATE_DEFAULT
) (
    input  logic IClk,
    input  logic RST_N,
    input  logic i_en,
    output logic o_tick
);

    localparam int              CNT_W  = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(RATE - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counter freezes (not cleared) while disabled so a pause resumes mid-period.
    always_ff @(posedge IClk or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/deser_1_to_8.sv
`default_nettype none
// ============================================================================
// Module  : deser_1_to_8
// Brief   : Serial-to-byte deserializer, LSB first, with frame sync and overrun.
// Revision: 1.0
// ============================================================================
import deser_1_to_8_pkg::*;

module deser_1_to_8 #(
    parameter int RATE = RATE_DEFAULT
) (
    input  logic              IClk,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              F,
    input  logic              SYNC,
    input  logic              ACK,
    output logic [IDX_W-1:0]  A,
    output logic [BYTE_W-1:0] O,
    output logic              VALID,
    output logic              OVR
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(BYTE_W - 1);

    run_state_t        w_state;
    logic              w_tick;
    logic              w_complete;
    logic [BYTE_W-1:0] w_buf_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;

    logic [IDX_W-1:0]  r_idx;
    logic [BYTE_W-1:0] r_buf;
    logic [BYTE_W-1:0] r_o;
    logic              r_valid;
    logic              r_ovr;

    assign w_state = EN ? ST_IDLE : ST_RUN;

    tick_div #(
        .RATE (RATE)
    ) u_tick_div (
        .IClk   (IClk),
        .RST_N  (RST_N),
        .i_en   (w_state == ST_RUN),
        .o_tick (w_tick)
    );

    always_comb begin
        w_buf_nxt  = r_buf;
        w_idx_nxt  = r_idx;
        w_complete = 1'b0;
        if (w_tick) begin
            if (SYNC) begin
                w_buf_nxt    = '0;
                w_buf_nxt[0] = F;
                w_idx_nxt    = IDX_W'(1);
            end else begin
                w_buf_nxt[r_idx] = F;
                w_idx_nxt        = r_idx + IDX_W'(1);
                w_complete       = (r_idx == c_last_idx);
            end
        end
    end

    // A completion wins over ACK; overrun only when a pending byte is lost unacked.
    always_ff @(posedge IClk or negedge RST_N) begin
        if (!RST_N) begin
            r_idx   <= '0;
            r_buf   <= '0;
            r_o     <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_idx <= w_idx_nxt;
            r_buf <= w_buf_nxt;
            if (w_complete) begin
                r_o     <= w_buf_nxt;
                r_valid <= 1'b1;
                if (r_valid && !ACK) begin
                    r_ovr <= 1'b1;
                end
            end else if (ACK) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign A     = r_idx;
    assign O     = r_o;
    assign VALID = r_valid;
    assign OVR   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_deser_1_to_8.sv
`default_nettype none
// ============================================================================
// Module  : tb_deser_1_to_8
// Brief   : Directed bench for deser_1_to_8 with a cycle-level reference model.
// Revision: 1.0
// ============================================================================
module tb_deser_1_to_8;

    localparam int RATE = 4;

    logic       IClk;
    logic       RST_N;
    logic       EN;
    logic       F;
    logic       SYNC;
    logic       ACK;
    logic [2:0] A;
    logic [7:0] O;
    logic       VALID;
    logic       OVR;

    int errors = 0;
    int checks = 0;

    deser_1_to_8 #(
        .RATE (RATE)
    ) dut (
        .IClk  (IClk),
        .RST_N (RST_N),
        .EN    (EN),
        .F     (F),
        .SYNC  (SYNC),
        .ACK   (ACK),
        .A     (A),
        .O     (O),
        .VALID (VALID),
        .OVR   (OVR)
    );

    initial IClk = 1'b0;
    always #5 IClk = ~IClk;

    // Reference model: integer bit position, byte array of received bits.
    int       m_cnt;
    int       m_a;
    bit [7:0] m_buf;
    bit [7:0] m_o;
    bit       m_valid;
    bit       m_ovr;

    always @(posedge IClk or negedge RST_N) begin
        bit done;
        if (!RST_N) begin
            m_cnt = 0; m_a = 0; m_buf = 8'h00; m_o = 8'h00; m_valid = 0; m_ovr = 0;
        end else begin
            done = 0;
            if (!EN) begin
                if (m_cnt == RATE - 1) begin
                    if (SYNC) begin
                        m_buf    = 8'h00;
                        m_buf[0] = F;
                        m_a      = 1;
                    end else begin
                        m_buf[m_a] = F;
                        done       = (m_a == 7);
                        m_a        = (m_a + 1) % 8;
                    end
                end
                m_cnt = (m_cnt + 1) % RATE;
            end
            if (done) begin
                if (m_valid && !ACK) m_ovr = 1;
                m_o     = m_buf;
                m_valid = 1;
            end else if (ACK) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge IClk) begin
        chk("model_A", 32'(A), 32'(m_a));
        chk("model_O", 32'(O), 32'(m_o));
        chk("model_VALID", 32'(VALID), 32'(m_valid));
        chk("model_OVR", 32'(OVR), 32'(m_ovr));
    end

    // One bit period; inputs held for RATE cycles so the tick edge sees them.
    task automatic send(input logic f, input logic s, input logic ack_at_tick);
        F    = f;
        SYNC = s;
        for (int i = 0; i < RATE; i++) begin
            ACK = (i == RATE - 1) ? ack_at_tick : 1'b0;
            @(posedge IClk); #2;
        end
        ACK  = 1'b0;
        SYNC = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sync_first, input logic ack_last);
        for (int i = 0; i < 8; i++) begin
            send(b[i], sync_first && (i == 0), ack_last && (i == 7));
        end
    endtask

    task automatic pulse_reset();
        @(posedge IClk); #2;
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        RST_N = 1'b0; EN = 1'b0; F = 1'b0; SYNC = 1'b0; ACK = 1'b0;
        #22;
        chk("rst_A", 32'(A), 32'h0);
        chk("rst_O", 32'(O), 32'h0);
        chk("rst_VALID", 32'(VALID), 32'h0);
        chk("rst_OVR", 32'(OVR), 32'h0);
        @(posedge IClk); #4;
        RST_N = 1'b1;

        // Basic byte with sync on first bit
        send_byte(8'h4D, 1'b1, 1'b0);
        chk("b1_O", 32'(O), 32'h4D);
        chk("b1_VALID", 32'(VALID), 32'h1);
        chk("b1_A", 32'(A), 32'h0);
        ACK = 1'b1; @(posedge IClk); #2; ACK = 1'b0;
        chk("ack_VALID", 32'(VALID), 32'h0);

        // Overrun
        send_byte(8'hA5, 1'b0, 1'b0);
        chk("ovr_first_OVR", 32'(OVR), 32'h0);
        send_byte(8'h3C, 1'b0, 1'b0);
        chk("ovr_O", 32'(O), 32'h3C);
        chk("ovr_VALID", 32'(VALID), 32'h1);
        chk("ovr_OVR", 32'(OVR), 32'h1);

        // ACK coincident with completion
        pulse_reset();
        chk("rst2_OVR", 32'(OVR), 32'h0);
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b1);
        chk("coack_VALID", 32'(VALID), 32'h1);
        chk("coack_OVR", 32'(OVR), 32'h0);
        chk("coack_O", 32'(O), 32'h3C);

        // Pause after bit 3
        b = 8'h96;
        for (int i = 0; i < 4; i++) send(b[i], 1'b0, 1'b0);
        EN = 1'b1;
        repeat (10) begin @(posedge IClk); #2; end
        chk("pause_A", 32'(A), 32'h4);
        EN = 1'b0;
        for (int i = 4; i < 8; i++) send(b[i], 1'b0, 1'b0);
        chk("pause_O", 32'(O), 32'h96);
        chk("pause_A_end", 32'(A), 32'h0);

        // Resync at bit index 5
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b0);
        chk("presync_A", 32'(A), 32'h5);
        b = 8'h5A;
        send(b[0], 1'b1, 1'b0);
        chk("sync_A", 32'(A), 32'h1);
        for (int i = 1; i < 8; i++) send(b[i], 1'b0, 1'b0);
        chk("sync_O", 32'(O), 32'h5A);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 1'b0);
        chk("prerst_A", 32'(A), 32'h6);
        #1;
        RST_N = 1'b0;
        #1;
        chk("arst_A", 32'(A), 32'h0);
        chk("arst_O", 32'(O), 32'h0);
        chk("arst_VALID", 32'(VALID), 32'h0);
        chk("arst_OVR", 32'(OVR), 32'h0);
        RST_N = 1'b1;
        send_byte(8'hC3, 1'b0, 1'b0);
        chk("post_rst_O", 32'(O), 32'hC3);
        chk("post_rst_VALID", 32'(VALID), 32'h1);
        chk("post_rst_OVR", 32'(OVR), 32'h0);

        @(posedge IClk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/deser_1_to_8.md
DESER_1_TO_8 -- requirements
Module: deser_1_to_8

Interface
REQ-001 Parameter RATE, default 50000000, meaning IClk cycles per bit period; legal range 2..2^31-1.
REQ-002 IClk  input  1  sole clock; all state updates on posedge IClk.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 EN  input  1  active-low run enable: 0 = sample and count, 1 = hold all state.
REQ-005 F  input  1  serial data bit, one bit per bit period, bit 0 first.
REQ-006 SYNC  input  1  frame-align strobe; high at a tick forces that sample into bit 0.
REQ-007 ACK  input  1  consumer acknowledge of the current byte.
REQ-008 A  output  3  index of the bit to be sampled at the next tick.
REQ-009 O  output  8  last completed byte.
REQ-010 VALID  output  1  O holds an unacknowledged byte.
REQ-011 OVR  output  1  sticky overrun flag.

Function
REQ-012 Tick: internal counter 0..RATE-1, wraps; tick asserted for exactly one IClk cycle when counter == RATE-1 and EN == 0.
REQ-013 While EN == 1: tick counter, A, shift buffer, O, VALID and OVR hold; ACK still clears VALID.
REQ-014 At a tick with SYNC == 0: buffer[A] <= F; A <= A+1 mod 8 (7 wraps to 0).
REQ-015 At a tick with SYNC == 1: buffer cleared, buffer[0] <= F, A <= 1.
REQ-016 Completion = tick with A == 7 and SYNC == 0; next cycle O holds the full byte including that bit; buffer unchanged otherwise.
REQ-017 Latency: O and VALID update in the cycle after the completing tick; no combinational path from F to O.
REQ-018 VALID set on completion; cleared by ACK == 1 in a cycle with no completion.
REQ-019 Completion and ACK in the same cycle: VALID stays 1, new byte loaded, OVR unchanged.
REQ-020 Completion while VALID == 1 and ACK == 0: O overwritten, OVR <= 1.
REQ-021 OVR cleared only by reset.
REQ-022 SYNC outside a tick has no effect.
REQ-023 States: IDLE (EN == 1), RUN (EN == 0); EN change takes effect next cycle; tick counter neither cleared nor advanced in IDLE.

Reset
REQ-024 RST_N low: tick counter 0, A = 0, buffer 0, O = 8'h00, VALID = 0, OVR = 0, immediately and regardless of IClk.
REQ-025 Reset mid-frame discards the partial byte; after release the first tick samples into bit 0.
REQ-026 Release is synchronized externally; no tick occurs in the first RATE-1 cycles after release.

Structure
REQ-027 Shared package holds RATE default (50000000), bit-index width 3, byte width 8.
REQ-028 One sub-module, tick_div, contains the RATE counter and tick output; deser_1_to_8 instantiates it once.
REQ-029 Bit index, buffer, O, VALID and OVR reside in deser_1_to_8.

Verification (RATE = 4)
REQ-030 Reset, EN = 0, SYNC pulse at first tick, F = 1,0,1,1,0,0,1,0 over 8 ticks -> O = 8'h4D, VALID = 1 one cycle after the 8th tick, A = 0.
REQ-031 Two bytes 8'hA5 then 8'h3C, no ACK -> O = 8'h3C, VALID = 1, OVR = 1.
REQ-032 ACK asserted exactly on the completion cycle of the second byte -> VALID = 1, OVR = 0, O = second byte.
REQ-033 EN = 1 for 10 cycles after bit 3 -> A stays 4, tick count frozen; resume completes byte with correct bits.
REQ-034 SYNC at bit index 5 -> A = 1, byte completes 7 ticks later containing only post-SYNC bits.
REQ-035 RST_N pulsed low at bit 6 asynchronously -> all outputs 0 within the same cycle; next byte assembles from bit 0.
